// File: rtl/skynet_mac_pkg.sv
// skynet_mac_pkg -- mode encodings and the shared round/saturate helper for the MAC pipe.
// Rev 1.0
`default_nettype none

package skynet_mac_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // Working width for the rounding helper; wide enough that acc + bias never overflows.
  localparam int SR_W = 64;

  // Returns {sat, value}; value is the rounded, clipped result sign-extended to SR_W bits.
  function automatic logic [SR_W:0] sat_round(input logic signed [SR_W-1:0] acc,
                                               input int shift,
                                               input int out_w);
    logic signed [SR_W-1:0] bias;
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    bias = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    r    = (acc + bias) >>> shift;
    hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (out_w - 1));
    if (r > hi) begin
      return {1'b1, hi};
    end else if (r < lo) begin
      return {1'b1, lo};
    end
    return {1'b0, r};
  endfunction

endpackage

`default_nettype wire

// File: rtl/skynet_mac_lane.sv
// skynet_mac_lane -- one MAC lane: operand register, product pipe, accumulator, round/saturate.
// Rev 1.0
`default_nettype none

module skynet_mac_lane
  import skynet_mac_pkg::*;
#(
  parameter int A_W        = 9,
  parameter int B_W        = 11,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    advance,
  input  logic                    acc_en,
  input  logic                    acc_load,
  input  logic                    out_load,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0]   a_q;
  logic signed [B_W-1:0]   b_q;
  logic signed [P_W-1:0]   prod_full;
  logic signed [ACC_W-1:0] prod_pipe [MUL_STAGES];
  logic signed [ACC_W-1:0] acc;
  logic [SR_W:0]           rounded;
  logic                    unused_rounded;

  assign prod_full      = P_W'(a_q) * P_W'(b_q);
  assign rounded        = sat_round(SR_W'(acc), SHIFT, OUT_W);
  assign unused_rounded = ^rounded[SR_W-1:OUT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int k = 0; k < MUL_STAGES; k++) begin
        prod_pipe[k] <= '0;
      end
      acc <= '0;
      res <= '0;
      sat <= 1'b0;
    end else if (advance) begin
      a_q          <= a;
      b_q          <= b;
      prod_pipe[0] <= ACC_W'(prod_full);
      for (int k = 1; k < MUL_STAGES; k++) begin
        prod_pipe[k] <= prod_pipe[k-1];
      end
      // Overflow wraps by design; the accumulator is sized by the integrator.
      if (acc_en) begin
        acc <= acc_load ? prod_pipe[MUL_STAGES-1] : acc + prod_pipe[MUL_STAGES-1];
      end
      if (out_load) begin
        res <= rounded[OUT_W-1:0];
        sat <= rounded[SR_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/skynet_mac_pipe.sv
// skynet_mac_pipe -- multi-lane signed MAC pipeline with packet accumulation and valid/ready flow.
// Rev 1.0
`default_nettype none

module skynet_mac_pipe
  import skynet_mac_pkg::*;
#(
  parameter int A_W        = 9,
  parameter int B_W        = 11,
  parameter int LANES      = 4,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  input  logic                   in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);

  // Operand register plus MUL_STAGES product registers carry the beat sideband.
  localparam int NST = MUL_STAGES + 1;

  logic           stall;
  logic           advance;
  logic           accept;
  logic           first_beat;
  logic           beat_mode;
  logic           beat_last;
  logic           pkt_open;
  logic           mode_q;
  logic [NST-1:0] v_pipe;
  logic [NST-1:0] load_pipe;
  logic [NST-1:0] emit_pipe;
  logic           acc_v;
  logic           acc_emit;
  logic           out_load;

  assign stall      = out_valid && !out_ready;
  assign advance    = !stall;
  assign in_ready   = !stall && ap_rst_n;
  assign accept     = in_valid && in_ready;
  assign first_beat = !pkt_open;
  assign beat_mode  = first_beat ? in_mode : mode_q;
  // Multiply-only beats always close their own one-beat packet.
  assign beat_last  = (beat_mode == MODE_MUL) || in_last;
  assign out_load   = acc_v && acc_emit;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      v_pipe    <= '0;
      load_pipe <= '0;
      emit_pipe <= '0;
      acc_v     <= 1'b0;
      acc_emit  <= 1'b0;
      out_valid <= 1'b0;
      pkt_open  <= 1'b0;
      mode_q    <= MODE_MUL;
    end else if (advance) begin
      v_pipe    <= {v_pipe[NST-2:0], accept};
      load_pipe <= {load_pipe[NST-2:0], first_beat};
      emit_pipe <= {emit_pipe[NST-2:0], beat_last};
      acc_v     <= v_pipe[NST-1];
      acc_emit  <= emit_pipe[NST-1];
      out_valid <= out_load;
      if (accept) begin
        pkt_open <= !beat_last;
        if (first_beat) begin
          mode_q <= in_mode;
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    skynet_mac_lane #(
      .A_W        (A_W),
      .B_W        (B_W),
      .ACC_W      (ACC_W),
      .OUT_W      (OUT_W),
      .SHIFT      (SHIFT),
      .MUL_STAGES (MUL_STAGES)
    ) u_lane (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .advance  (advance),
      .acc_en   (v_pipe[NST-1]),
      .acc_load (load_pipe[NST-1]),
      .out_load (out_load),
      .a        (in_a[g*A_W +: A_W]),
      .b        (in_b[g*B_W +: B_W]),
      .res      (out_data[g*OUT_W +: OUT_W]),
      .sat      (out_sat[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_skynet_mac_pipe.sv
// tb_skynet_mac_pipe -- directed and randomized checks of skynet_mac_pipe against a packet-level model.
// Rev 1.0
`default_nettype none

module tb_skynet_mac_pipe;

  localparam int A_W        = 9;
  localparam int B_W        = 11;
  localparam int LANES      = 4;
  localparam int ACC_W      = 24;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 4;
  localparam int MUL_STAGES = 2;

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    logic [LANES-1:0]       sat;
  } res_t;

  logic                   clk = 1'b0;
  logic                   ap_rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*A_W-1:0]   in_a;
  logic [LANES*B_W-1:0]   in_b;
  logic                   in_mode;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;

  int     checks   = 0;
  int     failures = 0;
  int     sa [LANES];
  int     sb [LANES];
  res_t   exp_q [$];
  res_t   got_q [$];
  res_t   mon_r;
  bit     m_open = 1'b0;
  bit     m_mode = 1'b0;
  longint m_sum [LANES];
  bit     rnd_done;

  skynet_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .LANES(LANES), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .SHIFT(SHIFT), .MUL_STAGES(MUL_STAGES)
  ) dut (
    .ap_clk    (clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Record every result the DUT hands over (transfer happens at the following rising edge).
  always @(negedge clk) begin
    if (ap_rst_n && out_valid && out_ready) begin
      mon_r.data = out_data;
      mon_r.sat  = out_sat;
      got_q.push_back(mon_r);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: wrap the exact packet sum to ACC_W, round half up by 2^SHIFT, clip to OUT_W.
  function automatic logic [OUT_W:0] model_out(input longint s);
    longint full, w, bias, r, hi, lo;
    full = longint'(1) << ACC_W;
    w    = s & (full - 1);
    if (w >= (full >> 1)) w = w - full;
    bias = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
    r    = (w + bias) >>> SHIFT;
    hi   = (longint'(1) << (OUT_W - 1)) - 1;
    lo   = -(longint'(1) << (OUT_W - 1));
    if (r > hi) return {1'b1, OUT_W'(hi)};
    if (r < lo) return {1'b1, OUT_W'(lo)};
    return {1'b0, OUT_W'(r)};
  endfunction

  function automatic longint lane_val(input int i);
    logic signed [OUT_W-1:0] t;
    t = out_data[i*OUT_W +: OUT_W];
    return longint'(t);
  endfunction

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < LANES; i++) begin
      sa[i] = a;
      sb[i] = b;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < LANES; i++) begin
      sa[i] = int'($urandom_range(511)) - 256;
      sb[i] = int'($urandom_range(2047)) - 1024;
    end
  endtask

  // Present one beat from sa/sb, wait (bounded) until taken, then update the packet model.
  task automatic drive_beat(input logic mode, input logic last);
    int           waitc;
    bit           first;
    bit           md;
    res_t         r;
    logic [OUT_W:0] mo;
    for (int i = 0; i < LANES; i++) begin
      in_a[i*A_W +: A_W] = A_W'(sa[i]);
      in_b[i*B_W +: B_W] = B_W'(sb[i]);
    end
    in_mode  = mode;
    in_last  = last;
    in_valid = 1'b1;
    waitc    = 0;
    @(negedge clk);
    while (!in_ready && waitc < 200) begin
      waitc++;
      @(negedge clk);
    end
    check("beat_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    first = !m_open;
    md    = first ? mode : m_mode;
    for (int i = 0; i < LANES; i++) begin
      m_sum[i] = (first ? 0 : m_sum[i]) + longint'(sa[i]) * longint'(sb[i]);
    end
    if (first) m_mode = mode;
    if (!md || last) begin
      for (int i = 0; i < LANES; i++) begin
        mo = model_out(m_sum[i]);
        r.data[i*OUT_W +: OUT_W] = mo[OUT_W-1:0];
        r.sat[i] = mo[OUT_W];
      end
      exp_q.push_back(r);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic wait_out(input string tag, output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic compare_all(input string tag);
    int   n;
    res_t e;
    res_t g;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, g.data, e.data);
      check({tag, "_sat"}, g.sat, e.sat);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int             cyc;
    logic [LANES*OUT_W-1:0] snap;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) m_sum[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    ap_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    // 1: multiply only, latency
    set_all(0, 0);
    sa[0] = 3;    sb[0] = 5;
    sa[1] = -256; sb[1] = -1024;
    drive_beat(1'b0, 1'b0);
    wait_out("t1_wait", cyc);
    check("t1_latency", cyc, MUL_STAGES + 2);
    check("t1_lane0", lane_val(0), 1);
    check("t1_lane1", lane_val(1), 16384);
    check("t1_sat", out_sat, 0);
    compare_all("t1");

    // 2: four-beat accumulate
    set_all(100, 100);
    for (int k = 0; k < 4; k++) drive_beat(1'b1, k == 3);
    wait_out("t2_wait", cyc);
    for (int i = 0; i < LANES; i++) check("t2_lane", lane_val(i), 2500);
    compare_all("t2");

    // 3: positive then negative saturation
    set_all(-256, -1024);
    for (int k = 0; k < 20; k++) drive_beat(1'b1, k == 19);
    wait_out("t3a_wait", cyc);
    check("t3a_lane0", lane_val(0), 32767);
    check("t3a_lane3", lane_val(3), 32767);
    check("t3a_sat", out_sat, {LANES{1'b1}});
    compare_all("t3a");
    set_all(-256, 1023);
    for (int k = 0; k < 4; k++) drive_beat(1'b1, k == 3);
    wait_out("t3b_wait", cyc);
    check("t3b_lane0", lane_val(0), -32768);
    check("t3b_lane2", lane_val(2), -32768);
    check("t3b_sat", out_sat, {LANES{1'b1}});
    compare_all("t3b");

    // 4: continuous beats with a 10-cycle output stall
    fork
      begin
        for (int k = 0; k < 14; k++) begin
          set_rand();
          drive_beat(1'b0, 1'b0);
        end
      end
      begin
        repeat (6) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        snap = out_data;
        check("t4_stall_valid", out_valid, 1);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("t4_in_ready", in_ready, 0);
          check("t4_stable", out_data, snap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    compare_all("t4");

    // 5: reset mid-packet discards the partial sum
    set_all(50, 50);
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b1, 1'b0);
    ap_rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_sat", out_sat, 0);
    ap_rst_n = 1'b1;
    m_open   = 1'b0;
    set_all(2, 8);
    drive_beat(1'b1, 1'b1);
    wait_out("t5_wait", cyc);
    for (int i = 0; i < LANES; i++) check("t5_lane", lane_val(i), 1);
    compare_all("t5");

    // 6: mode latched on first beat; next mode-0 beat emits at once
    set_all(10, 16);
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b1);
    wait_out("t6_wait", cyc);
    check("t6_lane0", lane_val(0), 20);
    drive_beat(1'b0, 1'b0);
    compare_all("t6");

    // Random packets with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          set_rand();
          if ($urandom_range(4) == 0) begin
            @(posedge clk);
            #1;
          end
          drive_beat(1'($urandom_range(1)), $urandom_range(3) == 0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    if (m_open) begin
      set_rand();
      drive_beat(1'b1, 1'b1);
    end
    compare_all("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
